// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: FSM state encoding, GRB field offsets and default
// line timing, used by both the receiver and the transmitter.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ws2812_state_t;

    localparam int PIXEL_BITS = 24;

    // Bit offsets of each colour byte inside a 24-bit GRB word.
    localparam int G_OFS = 16;
    localparam int R_OFS = 8;
    localparam int B_OFS = 0;

    // Nominal line timing in nanoseconds.
    localparam int unsigned T0H_NS           = 400;
    localparam int unsigned T1H_NS           = 800;
    localparam int unsigned T1_THRESH_DEF_NS = 600;
    localparam int unsigned TMAX_HIGH_DEF_NS = 2000;
    localparam int unsigned TRESET_DEF_NS    = 50000;

    // Nanoseconds to whole clock cycles, rounded down; 64-bit product so
    // long reset periods at high clock rates do not overflow.
    function automatic int unsigned ns_to_cycles(input longint unsigned f_clk_hz,
                                                 input longint unsigned t_ns);
        longint unsigned cycles;
        cycles = (f_clk_hz * t_ns) / 64'd1_000_000_000;
        return cycles[31:0];
    endfunction

endpackage

// File: rtl/ws2812_pulse_timer.sv
// Line front end: 2-flop synchroniser, edge detect on the synchronised line and
// a saturating counter of cycles since the last edge or FSM state change.
module ws2812_pulse_timer #(
    parameter int          CW   = 12,
    parameter int unsigned CMAX = 2500
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          din,
    input  logic          clr,
    output logic          level,
    output logic          rise,
    output logic          fall,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CMAX_C = CW'(CMAX);

    // [0] first sync flop, [1] synchronised line, [2] previous synchronised value
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise || fall || clr) begin
            cnt <= '0;
        end else if (cnt != CMAX_C) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes GRB pixels from the serial line and flags frame latches.
// Define WS2812_RX_FORWARD_EN to build the cascaded forward output on ws2812_dout.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned F_CLK        = 50_000_000,
    parameter int unsigned T1_THRESH_NS = T1_THRESH_DEF_NS,
    parameter int unsigned TMAX_HIGH_NS = TMAX_HIGH_DEF_NS,
    parameter int unsigned TRESET_NS    = TRESET_DEF_NS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws2812_din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] pixel_count,
    output logic        frame_done,
    output logic        rx_error,
    output logic        ws2812_dout,
    output logic [1:0]  dbg_state
);

    localparam int unsigned T1   = ns_to_cycles(64'(F_CLK), 64'(T1_THRESH_NS));
    localparam int unsigned TMAX = ns_to_cycles(64'(F_CLK), 64'(TMAX_HIGH_NS));
    localparam int unsigned TRST = ns_to_cycles(64'(F_CLK), 64'(TRESET_NS));
    localparam int          CW   = $clog2(TRST + 1);

    localparam logic [CW-1:0] T1_C     = CW'(T1);
    localparam logic [CW-1:0] TMAX_C   = CW'(TMAX);
    localparam logic [CW-1:0] TRST_C   = CW'(TRST);
    localparam logic [4:0]    PIX_LAST = 5'(PIXEL_BITS);

    ws2812_state_t state_q, state_d;
    logic          seen_q, seen_d;
    logic          level, rise, fall, timer_clr;
    logic [CW-1:0] cnt;
    logic          shift_en, err_d, done_d;
    logic [23:0]   shift_q;
    logic [4:0]    bit_cnt;

    // Every state change restarts the width count, as do line edges.
    assign timer_clr = (state_d != state_q);

    ws2812_pulse_timer #(
        .CW   (CW),
        .CMAX (TRST)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .din   (ws2812_din),
        .clr   (timer_clr),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .cnt   (cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
        end
    end

    // seen_q: a full latch-length low has been observed, so the next rising
    // edge is known to start a frame rather than land mid-pixel.
    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        shift_en = 1'b0;
        err_d    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!level && cnt == TRST_C) begin
                    seen_d = 1'b1;
                end
                if (rise && seen_q) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt > TMAX_C) begin
                    state_d = ST_IDLE;
                    seen_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (fall) begin
                    state_d  = ST_LOW;
                    shift_en = 1'b1;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (cnt == TRST_C) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = (bit_cnt != 5'd0);
                end
            end
            default: begin
                state_d = ST_IDLE;
                seen_d  = 1'b0;
            end
        endcase
    end

    assign dbg_state = state_q;

    // pixel_valid, frame_done and rx_error are single-cycle strobes with no
    // backpressure: a consumer must capture pixel_data in the valid cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_count <= '0;
            frame_done  <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= done_d;
            rx_error    <= err_d;
            if (err_d || done_d) begin
                bit_cnt <= '0;
            end else if (bit_cnt == PIX_LAST) begin
                pixel_data  <= shift_q;
                pixel_valid <= 1'b1;
                bit_cnt     <= '0;
                if (pixel_count != 16'hFFFF) begin
                    pixel_count <= pixel_count + 16'd1;
                end
            end else if (shift_en) begin
                shift_q <= {shift_q[PIXEL_BITS-2:0], (cnt > T1_C)};
                bit_cnt <= bit_cnt + 5'd1;
            end
            // Count stays visible in the frame_done cycle, clears the cycle after.
            if (frame_done) begin
                pixel_count <= '0;
            end
        end
    end

`ifdef WS2812_RX_FORWARD_EN
    logic fwd_q;

    // Armed once this device has taken its pixel; the line is low at that point,
    // so gating the synchronised line passes everything from the next rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_q <= 1'b0;
        end else if (err_d || done_d) begin
            fwd_q <= 1'b0;
        end else if (bit_cnt == PIX_LAST && pixel_count == 16'd0) begin
            fwd_q <= 1'b1;
        end
    end

    assign ws2812_dout = fwd_q & level;
`else
    assign ws2812_dout = 1'b0;
`endif

endmodule
